// File: rtl/hwpe_ctrl_package.sv
// Shared types and helpers for the HWPE control peripheral arbiter.
package hwpe_ctrl_package;

    localparam int unsigned HWPE_CTRL_ARB_MAX_NBREQ = 8;
    localparam int unsigned HWPE_CTRL_ARB_IDX_W     = $clog2(HWPE_CTRL_ARB_MAX_NBREQ);

    typedef logic [HWPE_CTRL_ARB_IDX_W-1:0] arb_idx_t;

    // Index following idx in a ring of n initiators.
    function automatic arb_idx_t arb_next_idx(input arb_idx_t idx, input int unsigned n);
        return (32'(idx) + 32'd1 >= n) ? '0 : idx + arb_idx_t'(1);
    endfunction

endpackage

// File: rtl/hwpe_ctrl_arb_idx_fifo.sv
// Small synchronous FIFO holding the initiator index of each outstanding transfer.
module hwpe_ctrl_arb_idx_fifo #(
    parameter int unsigned Width = 3,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] data_in,
    output logic [Width-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW:0]      wr_ptr;
    logic [PtrW:0]      rd_ptr;
    logic [Width-1:0]   mem [Depth];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                      (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
    assign data_out = mem[rd_ptr[PtrW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wr_ptr[PtrW-1:0]] <= data_in;
                wr_ptr                <= wr_ptr + (PtrW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (PtrW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/hwpe_ctrl_periph_arbiter.sv
// Round-robin arbiter sharing one peripheral target among NbReq initiators.
// Optional macro HWPE_CTRL_PERIPH_ARB_PRIO_EN gives initiator 0 fixed top priority.
module hwpe_ctrl_periph_arbiter
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned NbReq          = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned IdWidth        = 8,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NbReq-1:0]                in_req_i,
    output logic [NbReq-1:0]                in_gnt_o,
    input  logic [NbReq*AddrWidth-1:0]      in_add_i,
    input  logic [NbReq-1:0]                in_wen_i,
    input  logic [NbReq*(DataWidth/8)-1:0]  in_be_i,
    input  logic [NbReq*DataWidth-1:0]      in_data_i,
    input  logic [NbReq*IdWidth-1:0]        in_id_i,
    output logic [DataWidth-1:0]            in_r_data_o,
    output logic [NbReq-1:0]                in_r_valid_o,
    output logic [IdWidth-1:0]              in_r_id_o,
    output logic                            out_req_o,
    output logic [AddrWidth-1:0]            out_add_o,
    output logic                            out_wen_o,
    output logic [DataWidth/8-1:0]          out_be_o,
    output logic [DataWidth-1:0]            out_data_o,
    output logic [IdWidth-1:0]              out_id_o,
    input  logic                            out_gnt_i,
    input  logic [DataWidth-1:0]            out_r_data_i,
    input  logic                            out_r_valid_i,
    input  logic [IdWidth-1:0]              out_r_id_i,
    output logic                            proto_err_o
);

    localparam int unsigned BeWidth = DataWidth / 8;

    arb_idx_t     rr_ptr;
    arb_idx_t     winner;
    arb_idx_t     fifo_head;
    logic         found;
    int unsigned  cand;
    logic         fifo_full;
    logic         fifo_empty;
    logic         xfer;
    logic         pop;

    // Scan from the round-robin pointer for the first requester.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned k = 0; k < NbReq; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NbReq) begin
                cand = cand - NbReq;
            end
`ifdef HWPE_CTRL_PERIPH_ARB_PRIO_EN
            if (!found && cand != 0 && in_req_i[cand]) begin
`else
            if (!found && in_req_i[cand]) begin
`endif
                found  = 1'b1;
                winner = arb_idx_t'(cand);
            end
        end
`ifdef HWPE_CTRL_PERIPH_ARB_PRIO_EN
        if (in_req_i[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
    end

    assign out_req_o = found && !fifo_full;
    assign xfer      = out_req_o && out_gnt_i;

    // Route the winner's fields to the target and the target grant back.
    always_comb begin
        out_add_o  = '0;
        out_wen_o  = 1'b0;
        out_be_o   = '0;
        out_data_o = '0;
        out_id_o   = '0;
        in_gnt_o   = '0;
        for (int unsigned i = 0; i < NbReq; i++) begin
            if (found && winner == arb_idx_t'(i)) begin
                out_add_o   = in_add_i[i*AddrWidth +: AddrWidth];
                out_wen_o   = in_wen_i[i];
                out_be_o    = in_be_i[i*BeWidth +: BeWidth];
                out_data_o  = in_data_i[i*DataWidth +: DataWidth];
                out_id_o    = in_id_i[i*IdWidth +: IdWidth];
                in_gnt_o[i] = out_gnt_i && !fifo_full;
            end
        end
    end

    assign pop         = out_r_valid_i && !fifo_empty;
    assign proto_err_o = out_r_valid_i && fifo_empty;
    assign in_r_data_o = out_r_data_i;
    assign in_r_id_o   = out_r_id_i;

    always_comb begin
        in_r_valid_o = '0;
        for (int unsigned i = 0; i < NbReq; i++) begin
            if (pop && fifo_head == arb_idx_t'(i)) begin
                in_r_valid_o[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (xfer) begin
`ifdef HWPE_CTRL_PERIPH_ARB_PRIO_EN
            if (winner != '0) begin
                rr_ptr <= arb_next_idx(winner, NbReq);
            end
`else
            rr_ptr <= arb_next_idx(winner, NbReq);
`endif
        end
    end

    hwpe_ctrl_arb_idx_fifo #(
        .Width (HWPE_CTRL_ARB_IDX_W),
        .Depth (MaxOutstanding)
    ) i_idx_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (xfer),
        .pop      (pop),
        .data_in  (winner),
        .data_out (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_hwpe_ctrl_periph_arbiter.sv
// Randomized bench for hwpe_ctrl_periph_arbiter against a queue-based reference model.
module tb_hwpe_ctrl_periph_arbiter;

    localparam int unsigned NBREQ  = 3;
    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned BW     = DW / 8;
    localparam int unsigned IW     = 8;
    localparam int unsigned MAXOUT = 4;

    logic                   clk_i;
    logic                   rst_ni;
    logic [NBREQ-1:0]       in_req_i;
    logic [NBREQ-1:0]       in_gnt_o;
    logic [NBREQ*AW-1:0]    in_add_i;
    logic [NBREQ-1:0]       in_wen_i;
    logic [NBREQ*BW-1:0]    in_be_i;
    logic [NBREQ*DW-1:0]    in_data_i;
    logic [NBREQ*IW-1:0]    in_id_i;
    logic [DW-1:0]          in_r_data_o;
    logic [NBREQ-1:0]       in_r_valid_o;
    logic [IW-1:0]          in_r_id_o;
    logic                   out_req_o;
    logic [AW-1:0]          out_add_o;
    logic                   out_wen_o;
    logic [BW-1:0]          out_be_o;
    logic [DW-1:0]          out_data_o;
    logic [IW-1:0]          out_id_o;
    logic                   out_gnt_i;
    logic [DW-1:0]          out_r_data_i;
    logic                   out_r_valid_i;
    logic [IW-1:0]          out_r_id_i;
    logic                   proto_err_o;

    hwpe_ctrl_periph_arbiter #(
        .NbReq          (NBREQ),
        .AddrWidth      (AW),
        .DataWidth      (DW),
        .IdWidth        (IW),
        .MaxOutstanding (MAXOUT)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .in_req_i      (in_req_i),
        .in_gnt_o      (in_gnt_o),
        .in_add_i      (in_add_i),
        .in_wen_i      (in_wen_i),
        .in_be_i       (in_be_i),
        .in_data_i     (in_data_i),
        .in_id_i       (in_id_i),
        .in_r_data_o   (in_r_data_o),
        .in_r_valid_o  (in_r_valid_o),
        .in_r_id_o     (in_r_id_o),
        .out_req_o     (out_req_o),
        .out_add_o     (out_add_o),
        .out_wen_o     (out_wen_o),
        .out_be_o      (out_be_o),
        .out_data_o    (out_data_o),
        .out_id_o      (out_id_o),
        .out_gnt_i     (out_gnt_i),
        .out_r_data_i  (out_r_data_i),
        .out_r_valid_i (out_r_valid_i),
        .out_r_id_i    (out_r_id_i),
        .proto_err_o   (proto_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_bad = 0;

    // Initiator-side pending transactions and target-side stimulus.
    bit            pend   [NBREQ];
    logic [AW-1:0] f_add  [NBREQ];
    logic          f_wen  [NBREQ];
    logic [BW-1:0] f_be   [NBREQ];
    logic [DW-1:0] f_data [NBREQ];
    logic [IW-1:0] f_id   [NBREQ];
    bit            t_gnt;
    bit            t_rv;
    logic [DW-1:0] t_rdata;
    logic [IW-1:0] t_rid;

    // Reference state: next-priority initiator and in-flight initiator order.
    int m_ptr;
    int m_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input bit [NBREQ-1:0] req, input int p);
        int best = -1;
        int bd   = NBREQ;
`ifdef HWPE_CTRL_PERIPH_ARB_PRIO_EN
        if (req[0]) return 0;
`endif
        for (int i = 0; i < NBREQ; i++) begin
`ifdef HWPE_CTRL_PERIPH_ARB_PRIO_EN
            if (i == 0) continue;
`endif
            if (req[i]) begin
                int d = (i - p + NBREQ) % NBREQ;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < NBREQ; i++) pend[i] = 1'b0;
        t_gnt   = 1'b0;
        t_rv    = 1'b0;
        t_rdata = '0;
        t_rid   = '0;
    endtask

    task automatic rand_stim(input int p_req, input int p_gnt, input int p_rv);
        for (int i = 0; i < NBREQ; i++) begin
            if (!pend[i] && $urandom_range(99) < p_req) begin
                pend[i]   = 1'b1;
                f_add[i]  = $urandom;
                f_wen[i]  = 1'($urandom_range(1));
                f_be[i]   = BW'($urandom);
                f_data[i] = $urandom;
                f_id[i]   = IW'($urandom);
            end
        end
        t_gnt   = ($urandom_range(99) < p_gnt);
        t_rv    = ($urandom_range(99) < p_rv);
        t_rdata = $urandom;
        t_rid   = IW'($urandom);
    endtask

    // Drive one cycle of stimulus, compare against the model, then advance the model.
    task automatic step();
        bit [NBREQ-1:0] req;
        int             w;
        bit             full;
        bit             empty;
        bit             e_req;
        bit             do_pop;
        logic [NBREQ-1:0] e_gnt;
        logic [NBREQ-1:0] e_rv;
        for (int i = 0; i < NBREQ; i++) begin
            req[i]                    = pend[i];
            in_req_i[i]               = pend[i];
            in_add_i[i*AW +: AW]      = pend[i] ? f_add[i]  : '0;
            in_wen_i[i]               = pend[i] ? f_wen[i]  : 1'b0;
            in_be_i[i*BW +: BW]       = pend[i] ? f_be[i]   : '0;
            in_data_i[i*DW +: DW]     = pend[i] ? f_data[i] : '0;
            in_id_i[i*IW +: IW]       = pend[i] ? f_id[i]   : '0;
        end
        out_gnt_i     = t_gnt;
        out_r_valid_i = t_rv;
        out_r_data_i  = t_rdata;
        out_r_id_i    = t_rid;
        #1;
        w      = pick(req, m_ptr);
        full   = (m_q.size() == MAXOUT);
        empty  = (m_q.size() == 0);
        e_req  = (w >= 0) && !full;
        e_gnt  = '0;
        if (e_req && t_gnt) e_gnt[w] = 1'b1;
        do_pop = t_rv && !empty;
        e_rv   = '0;
        if (do_pop) e_rv[m_q[0]] = 1'b1;

        chk("out_req",   64'(out_req_o),  64'(e_req));
        chk("out_add",   64'(out_add_o),  (w >= 0) ? 64'(f_add[w])  : 64'd0);
        chk("out_wen",   64'(out_wen_o),  (w >= 0) ? 64'(f_wen[w])  : 64'd0);
        chk("out_be",    64'(out_be_o),   (w >= 0) ? 64'(f_be[w])   : 64'd0);
        chk("out_data",  64'(out_data_o), (w >= 0) ? 64'(f_data[w]) : 64'd0);
        chk("out_id",    64'(out_id_o),   (w >= 0) ? 64'(f_id[w])   : 64'd0);
        chk("in_gnt",    64'(in_gnt_o),     64'(e_gnt));
        chk("in_r_valid",64'(in_r_valid_o), 64'(e_rv));
        chk("in_r_data", 64'(in_r_data_o),  64'(t_rdata));
        chk("in_r_id",   64'(in_r_id_o),    64'(t_rid));
        chk("proto_err", 64'(proto_err_o),  64'(t_rv && empty));

        if (do_pop) void'(m_q.pop_front());
        if (e_req && t_gnt) begin
            m_q.push_back(w);
            pend[w] = 1'b0;
`ifdef HWPE_CTRL_PERIPH_ARB_PRIO_EN
            if (w != 0) m_ptr = (w + 1) % NBREQ;
`else
            m_ptr = (w + 1) % NBREQ;
`endif
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic run_phase(input int n, input int p_req, input int p_gnt, input int p_rv);
        for (int c = 0; c < n; c++) begin
            rand_stim(p_req, p_gnt, p_rv);
            step();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_req"}, 64'(out_req_o),    64'd0);
        chk({tag, "_gnt"},     64'(in_gnt_o),     64'd0);
        chk({tag, "_rvalid"},  64'(in_r_valid_o), 64'd0);
        chk({tag, "_add"},     64'(out_add_o),    64'd0);
        chk({tag, "_proto"},   64'(proto_err_o),  64'd0);
    endtask

    task automatic drive_idle();
        in_req_i      = '0;
        in_add_i      = '0;
        in_wen_i      = '0;
        in_be_i       = '0;
        in_data_i     = '0;
        in_id_i       = '0;
        out_gnt_i     = 1'b0;
        out_r_valid_i = 1'b0;
        out_r_data_i  = '0;
        out_r_id_i    = '0;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive_idle();
        clear_stim();
        m_ptr = 0;
        m_q.delete();
        repeat (2) @(negedge clk_i);
        #1;
        check_reset_outputs("rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Unsolicited response right after reset.
        t_rv = 1'b1;
        t_rdata = 32'hA5A5_0000;
        step();
        t_rv = 1'b0;
        step();

        run_phase(400, 70, 70, 50);
        run_phase(12, 100, 100, 0);
        run_phase(20, 100, 100, 100);
        run_phase(300, 90, 40, 30);
        run_phase(200, 100, 100, 60);

        // Leave a couple of transfers outstanding, then reset mid-operation.
        run_phase(3, 100, 100, 0);
        rst_ni = 1'b0;
        drive_idle();
        clear_stim();
        m_ptr = 0;
        m_q.delete();
        #1;
        check_reset_outputs("midrst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        t_rv = 1'b1;
        step();
        t_rv = 1'b0;
        step();

        run_phase(400, 60, 60, 55);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_periph_arbiter.md
Name: hwpe_ctrl_periph_arbiter

Overview:
- Shares one peripheral target port (req/gnt address phase, r_valid response phase) among NbReq peripheral initiators.
- Round-robin arbitration of address phases; in-order response routing through a small outstanding-index FIFO.
- Sits between several control masters (e.g. core-side config port, debug/DMA config port) and the HWPE register file slave.

Parameters:
- NbReq, 2, number of requesting initiator ports (2..8).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; BeWidth = DataWidth/8.
- IdWidth, 8, transaction id width.
- MaxOutstanding, 4, depth of the outstanding-index FIFO (power of two, >=2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_req_i  in  NbReq  per-initiator request.
- in_gnt_o  out  NbReq  per-initiator grant.
- in_add_i  in  NbReq*AddrWidth  packed addresses, index i at [i*AddrWidth +: AddrWidth].
- in_wen_i  in  NbReq  write-enable-n (1 = read).
- in_be_i  in  NbReq*BeWidth  byte enables.
- in_data_i  in  NbReq*DataWidth  write data.
- in_id_i  in  NbReq*IdWidth  ids.
- in_r_data_o  out  DataWidth  response data, broadcast to all initiators.
- in_r_valid_o  out  NbReq  per-initiator response valid.
- in_r_id_o  out  IdWidth  response id, broadcast.
- out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o, out_id_o  out  1/AddrWidth/1/BeWidth/DataWidth/IdWidth  muxed request to target.
- out_gnt_i  in  1  target grant.
- out_r_data_i, out_r_valid_i, out_r_id_i  in  DataWidth/1/IdWidth  target response.
- proto_err_o  out  1  one-cycle pulse: r_valid arrived with FIFO empty.

Behaviour:
- Reset: rr pointer = 0, FIFO empty, proto_err_o = 0; all outputs combinationally 0 while no requests.
- Winner: first i with in_req_i[i]=1, scanning pointer, pointer+1, ... mod NbReq.
- out_req_o = |in_req_i & !fifo_full; out_add/wen/be/data/id = winner's fields (0 when no request).
- in_gnt_o[winner] = out_gnt_i & !fifo_full; all other grants 0. Combinational path gnt_i -> gnt_o, zero added latency.
- Handshake: transfer when out_req_o & out_gnt_i. On transfer: push winner index into FIFO; pointer <= (winner+1) mod NbReq.
- Pointer is unchanged when there is no transfer, so a stalled winner keeps priority. Requesters must hold req and fields stable until granted.
- Response: on out_r_valid_i with FIFO non-empty: in_r_valid_o[head] = 1, others 0; pop. r_data and r_id are passed through combinationally; zero latency.
- Empty FIFO + out_r_valid_i: response dropped, proto_err_o = 1 that cycle.
- Full FIFO (MaxOutstanding entries): out_req_o forced 0 and no grants, even if a pop occurs the same cycle.
- Simultaneous push and pop when not full: both occur; count unchanged.
- Target must return responses in grant order; out_r_id_i is not used for routing.
- Reset mid-operation: FIFO cleared, pointer = 0; in-flight responses after reset raise proto_err_o.

Optional Feature:
- Macro: HWPE_CTRL_PERIPH_ARB_PRIO_EN.
- Defined: initiator 0 has fixed top priority. When in_req_i[0]=1 it wins regardless of pointer, and its transfers do not update the pointer. Other initiators use round-robin among themselves.
- Undefined: pure round-robin as above.

Decomposition:
- hwpe_ctrl_package: localparam HWPE_CTRL_ARB_MAX_NBREQ = 8; typedef arb_idx_t (logic [$clog2(HWPE_CTRL_ARB_MAX_NBREQ)-1:0]).
- Sub-module hwpe_ctrl_arb_idx_fifo: a synchronous FIFO with async reset.
  - Ports: push, pop, data_in, data_out, full, empty.
  - Parameterized width and depth; wrap-around pointers plus an extra bit for full/empty.

Test Plan:
- NbReq=2, both req held, target gnt=1 always, r_valid one cycle after each gnt: grants alternate 0,1,0,1; each in_r_valid_o goes only to the matching initiator; r_data 0xA5A5_0000 reaches index 0.
- out_gnt_i=0 for 3 cycles with req0=1 and pointer=0: req1 asserted in cycle 2 does not steal the grant; req0 is granted first once gnt=1.
- MaxOutstanding=4, target grants but withholds responses: after 4 transfers out_req_o=0. One r_valid pops the FIFO; the next cycle allows the fifth transfer.
- out_r_valid_i pulse with no outstanding transfer: proto_err_o=1 for exactly one cycle; in_r_valid_o stays 0.
- Assert rst_ni=0 with 2 outstanding: FIFO empty and pointer 0 after release; a later r_valid raises proto_err_o.
- PRIO_EN, NbReq=3, all requesting continuously: initiator 0 is granted every cycle. Drop req0: grants go 1,2,1,2.
